// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer: FSM encoding,
// cause codes, flush-depth mask and vector-table addressing helpers.
package exception_sequencer_pkg;

   localparam logic [31:0] VEC_BASE_DEFAULT = 32'd2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_FLUSH    = 3'd1;
   localparam state_t ST_VEC_HI   = 3'd2;
   localparam state_t ST_VEC_LO   = 3'd3;
   localparam state_t ST_REDIRECT = 3'd4;
   localparam state_t ST_HANDLER  = 3'd5;
   localparam state_t ST_RETURN   = 3'd6;
   localparam state_t ST_HALT     = 3'd7;

   typedef enum logic [2:0] {
      CAUSE_NONE       = 3'd0,
      CAUSE_STACK_OVF  = 3'd1,
      CAUSE_STACK_UNF  = 3'd2,
      CAUSE_INV_INSTR  = 3'd3,
      CAUSE_DIV_ZERO   = 3'd4,
      CAUSE_IMEM_RANGE = 3'd5,
      CAUSE_DMEM_RANGE = 3'd6,
      CAUSE_RSVD       = 3'd7
   } cause_t;

   typedef struct packed {
      logic mem_wb;
      logic ex_mem;
      logic id_ex;
      logic if_id;
   } flush_t;

   localparam flush_t FLUSH_ALL  = 4'b1111;
   localparam flush_t FLUSH_EX   = 4'b0111;
   localparam flush_t FLUSH_ID   = 4'b0011;
   localparam flush_t FLUSH_NONE = 4'b0000;

   // The oldest faulting stage sets how deep the flush reaches; an unflagged
   // exception is treated like a decode-stage one.
   function automatic flush_t flush_depth(input logic mem, input logic ex, input logic id);
      flush_t f;
      if (mem)      f = FLUSH_ALL;
      else if (ex)  f = FLUSH_EX;
      else if (id)  f = FLUSH_ID;
      else          f = FLUSH_ID;
      return f;
   endfunction

   function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [2:0] cause,
                                            input logic lo);
      return base + {28'd0, cause, 1'b0} + {31'd0, lo};
   endfunction

endpackage

// File: rtl/exception_sequencer_vector_fetch.sv
// Two-word vector-table read: hi word then lo word, each held on the imem
// bus until acknowledged; returns the assembled 32-bit handler address.
module exception_sequencer_vector_fetch
   import exception_sequencer_pkg::*;
#(
   parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_hi,
   input  logic        fetch_lo,
   input  logic [2:0]  cause,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        hi_done,
   output logic        done,
   output logic [31:0] handler_addr
);

   logic [15:0] hi_q;
   logic [15:0] lo_q;

   // Request and address decode only from the sequencer state and the
   // registered cause, so they stay stable while waiting for the ack.
   assign imem_req  = fetch_hi | fetch_lo;
   assign imem_addr = imem_req ? vec_addr(VEC_BASE, cause, fetch_lo) : 32'd0;

   assign hi_done      = fetch_hi & imem_ack;
   assign done         = fetch_lo & imem_ack;
   assign handler_addr = {hi_q, lo_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= 16'd0;
         lo_q <= 16'd0;
      end else begin
         if (hi_done) hi_q <= imem_rdata;
         if (done)    lo_q <= imem_rdata;
      end
   end

endmodule

// File: rtl/exception_sequencer.sv
// Exception response sequencer: flush, vector fetch, PC redirect, handler
// residency tracking, return-from-interrupt and double-fault halt.
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exception_in,
   input  logic        exception_ID_in,
   input  logic        exception_EXE_in,
   input  logic        exception_MEM_in,
   input  logic [2:0]  cause_in,
   input  logic [31:0] epc_in,
   input  logic        rti_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ack,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        flush_EX_MEM,
   output logic        flush_MEM_WB,
   output logic        stall_pc,
   output logic        pc_load,
   output logic [31:0] pc_value,
   output logic        in_handler,
   output logic        double_fault
);

   state_t      state;
   state_t      state_nx;
   flush_t      flush_q;
   logic [2:0]  cause_q;
   logic [31:0] epc_q;

   logic        fetch_hi;
   logic        fetch_lo;
   logic        hi_done;
   logic        vec_done;
   logic [31:0] handler_addr;

   assign fetch_hi = (state == ST_VEC_HI);
   assign fetch_lo = (state == ST_VEC_LO);

   exception_sequencer_vector_fetch #(
      .VEC_BASE(VEC_BASE)
   ) u_vector_fetch (
      .clk          (clk),
      .reset        (reset),
      .fetch_hi     (fetch_hi),
      .fetch_lo     (fetch_lo),
      .cause        (cause_q),
      .imem_rdata   (imem_rdata),
      .imem_ack     (imem_ack),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .hi_done      (hi_done),
      .done         (vec_done),
      .handler_addr (handler_addr)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (exception_in) state_nx = ST_FLUSH;
         ST_FLUSH:    state_nx = (cause_in == CAUSE_NONE) ? ST_IDLE : ST_VEC_HI;
         ST_VEC_HI:   if (hi_done) state_nx = ST_VEC_LO;
         ST_VEC_LO:   if (vec_done) state_nx = ST_REDIRECT;
         ST_REDIRECT: state_nx = ST_HANDLER;
         // A fault inside the handler wins over a coincident return.
         ST_HANDLER: begin
            if (exception_in)  state_nx = ST_HALT;
            else if (rti_in)   state_nx = ST_RETURN;
         end
         ST_RETURN:   state_nx = ST_IDLE;
         ST_HALT:     state_nx = ST_HALT;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         flush_q <= FLUSH_NONE;
         cause_q <= 3'd0;
         epc_q   <= 32'd0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && exception_in)
            flush_q <= flush_depth(exception_MEM_in, exception_EXE_in, exception_ID_in);
         if (state == ST_FLUSH) begin
            cause_q <= cause_in;
            epc_q   <= epc_in;
         end
      end
   end

   // Every output is a decode of registered state, never of live inputs.
   always_comb begin
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_EX_MEM = 1'b0;
      flush_MEM_WB = 1'b0;
      stall_pc     = 1'b0;
      pc_load      = 1'b0;
      pc_value     = 32'd0;
      in_handler   = 1'b0;
      double_fault = 1'b0;
      case (state)
         ST_FLUSH: begin
            {flush_MEM_WB, flush_EX_MEM, flush_ID_EX, flush_IF_ID} = flush_q;
            stall_pc = 1'b1;
         end
         ST_VEC_HI, ST_VEC_LO: stall_pc = 1'b1;
         ST_REDIRECT: begin
            pc_load  = 1'b1;
            pc_value = handler_addr;
         end
         ST_HANDLER: in_handler = 1'b1;
         ST_RETURN: begin
            pc_load     = 1'b1;
            pc_value    = epc_q + 32'd1;
            flush_IF_ID = 1'b1;
         end
         ST_HALT: begin
            {flush_MEM_WB, flush_EX_MEM, flush_ID_EX, flush_IF_ID} = FLUSH_ALL;
            stall_pc     = 1'b1;
            double_fault = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed scenario table, randomized
// scenarios against a timeline model, and hand-written reset corner cases.
module tb_exception_sequencer;

   localparam int OW = 73;

   logic        clk = 1'b0;
   logic        reset;
   logic        exception_in, exception_ID_in, exception_EXE_in, exception_MEM_in;
   logic [2:0]  cause_in;
   logic [31:0] epc_in;
   logic        rti_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ack;
   logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
   logic        stall_pc, pc_load;
   logic [31:0] pc_value;
   logic        in_handler, double_fault;

   exception_sequencer #(.VEC_BASE(32'd2)) dut (
      .clk(clk), .reset(reset), .exception_in(exception_in),
      .exception_ID_in(exception_ID_in), .exception_EXE_in(exception_EXE_in),
      .exception_MEM_in(exception_MEM_in), .cause_in(cause_in), .epc_in(epc_in),
      .rti_in(rti_in), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .flush_IF_ID(flush_IF_ID),
      .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
      .stall_pc(stall_pc), .pc_load(pc_load), .pc_value(pc_value),
      .in_handler(in_handler), .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  flags;     // {MEM, EX, ID}
      logic [2:0]  cause;
      logic [31:0] epc;
      logic [15:0] hi, lo;
      int          d1, d2, k; // ack waits per word, handler dwell before rti/fault
      bit          dbl, rti_too, noise, directed;
      logic [3:0]  exp_mask;  // {MEM_WB, EX_MEM, ID_EX, IF_ID}
      logic [31:0] exp_pc, exp_ret;
   } scen_t;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [OW-1:0] pk(input logic req, input logic [31:0] addr,
                                        input logic [3:0] m, input logic stall,
                                        input logic pcl, input logic [31:0] pcv,
                                        input logic inh, input logic df);
      return {req, addr, m[0], m[1], m[2], m[3], stall, pcl, pcv, inh, df};
   endfunction

   function automatic logic [OW-1:0] observed();
      return {imem_req, imem_addr, flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
              stall_pc, pc_load, pc_value, in_handler, double_fault};
   endfunction

   function automatic scen_t mk(input logic [2:0] flags, input logic [2:0] cause,
                                input logic [31:0] epc, input logic [15:0] hi, lo,
                                input int d1, d2, k, input bit dbl, rti_too,
                                input logic [3:0] exp_mask, input logic [31:0] exp_pc, exp_ret);
      scen_t s;
      s.flags = flags; s.cause = cause; s.epc = epc; s.hi = hi; s.lo = lo;
      s.d1 = d1; s.d2 = d2; s.k = k; s.dbl = dbl; s.rti_too = rti_too;
      s.noise = 1'b0; s.directed = 1'b1;
      s.exp_mask = exp_mask; s.exp_pc = exp_pc; s.exp_ret = exp_ret;
      return s;
   endfunction

   task automatic chk(input string name, input int t, input logic [OW-1:0] got, exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
      end
   endtask

   task automatic chk32(input string name, input int t, input logic [31:0] got, exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
      end
   endtask

   task automatic idle_inputs();
      exception_in = 1'b0; exception_ID_in = 1'b0; exception_EXE_in = 1'b0;
      exception_MEM_in = 1'b0; cause_in = 3'd0; epc_in = 32'd0; rti_in = 1'b0;
      imem_ack = 1'b0; imem_rdata = 16'd0;
   endtask

   // Entered just after a rising edge with the DUT idle; t=0 is the cycle the
   // exception is raised. Expected outputs come from the event timeline.
   task automatic run(input scen_t s);
      int R, rt, tend;
      logic [OW-1:0] e;
      logic [3:0] m;
      logic [31:0] va;
      m    = s.flags[2] ? 4'b1111 : (s.flags[1] ? 4'b0111 : 4'b0011);
      va   = 32'd2 + 32'(s.cause) * 32'd2;
      R    = 4 + s.d1 + s.d2;
      rt   = R + 1 + s.k;
      tend = (s.cause == 3'd0) ? 4 : (s.dbl ? rt + 4 : rt + 3);
      for (int t = 0; t <= tend; t++) begin
         exception_in = (t == 0) || (s.cause != 3'd0 && s.dbl && t == rt);
         {exception_MEM_in, exception_EXE_in, exception_ID_in} = (t == 0) ? s.flags : 3'b000;
         if (s.noise && s.cause != 3'd0 && ((t >= 1 && t <= R) || (!s.dbl && t == rt + 1)))
            exception_in = 1'($urandom_range(0, 1));
         cause_in = (t >= 1) ? s.cause : 3'($urandom);
         epc_in   = (t >= 1) ? s.epc : $urandom;
         rti_in   = (s.cause != 3'd0 && t == rt && (!s.dbl || s.rti_too)) ||
                    (s.cause == 3'd0 && t == 3);
         imem_ack   = 1'b0;
         imem_rdata = 16'($urandom);
         if (t == 1 || (s.cause != 3'd0 && t > R)) imem_ack = 1'($urandom_range(0, 1));
         if (s.cause != 3'd0 && t == 2 + s.d1) begin imem_ack = 1'b1; imem_rdata = s.hi; end
         if (s.cause != 3'd0 && t == 3 + s.d1 + s.d2) begin imem_ack = 1'b1; imem_rdata = s.lo; end

         e = '0;
         if (t == 1) e = pk(0, 0, m, 1, 0, 0, 0, 0);
         else if (s.cause != 3'd0) begin
            if (t >= 2 && t <= 2 + s.d1)            e = pk(1, va, 4'b0, 1, 0, 0, 0, 0);
            else if (t >= 3 + s.d1 && t <= R - 1)   e = pk(1, va + 32'd1, 4'b0, 1, 0, 0, 0, 0);
            else if (t == R)                        e = pk(0, 0, 4'b0, 0, 1, {s.hi, s.lo}, 0, 0);
            else if (t > R && t <= rt)              e = pk(0, 0, 4'b0, 0, 0, 0, 1, 0);
            else if (s.dbl && t > rt)               e = pk(0, 0, 4'hF, 1, 0, 0, 0, 1);
            else if (!s.dbl && t == rt + 1)         e = pk(0, 0, 4'b0001, 0, 1, s.epc + 32'd1, 0, 0);
         end

         @(negedge clk);
         chk("cycle", t, observed(), e);
         if (s.directed) begin
            if (t == 1)
               chk32("flush_mask", t, {28'd0, flush_MEM_WB, flush_EX_MEM, flush_ID_EX, flush_IF_ID},
                     {28'd0, s.exp_mask});
            if (s.cause != 3'd0 && t == R)
               chk32("redirect_pc", t, pc_load ? pc_value : 32'hDEAD_BEEF, s.exp_pc);
            if (s.cause != 3'd0 && !s.dbl && t == rt + 1)
               chk32("return_pc", t, pc_load ? pc_value : 32'hDEAD_BEEF, s.exp_ret);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      if (s.cause != 3'd0 && s.dbl) begin
         reset = 1'b1;
         #1;
         chk("reset_clears_halt", 0, observed(), '0);
         @(posedge clk); #1;
         reset = 1'b0;
      end
   endtask

   scen_t tbl[6];
   scen_t rs;

   initial begin
      tbl[0] = mk(3'b100, 3'd1, 32'h40, 16'h0000, 16'h0100, 0, 0, 0, 0, 0,
                  4'b1111, 32'h0000_0100, 32'h41);
      tbl[1] = mk(3'b010, 3'd4, 32'h1234, 16'hABCD, 16'h0010, 3, 3, 1, 0, 0,
                  4'b0111, 32'hABCD_0010, 32'h1235);
      tbl[2] = mk(3'b001, 3'd2, 32'h40, 16'h0001, 16'h0002, 1, 0, 2, 0, 0,
                  4'b0011, 32'h0001_0002, 32'h41);
      tbl[3] = mk(3'b000, 3'd6, 32'hFFFF_FFFF, 16'h8000, 16'hFFFF, 0, 2, 0, 0, 0,
                  4'b0011, 32'h8000_FFFF, 32'h0);
      tbl[4] = mk(3'b011, 3'd3, 32'h77, 16'h0002, 16'h0200, 0, 1, 1, 1, 1,
                  4'b0111, 32'h0002_0200, 32'h0);
      tbl[5] = mk(3'b100, 3'd0, 32'h99, 16'h0, 16'h0, 0, 0, 0, 0, 0,
                  4'b1111, 32'h0, 32'h0);

      idle_inputs();
      reset = 1'b1;
      #1;
      chk("reset_state", 0, observed(), '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run(tbl[i]);

      // Reset while waiting on the lo vector word, then a normal exception.
      exception_in = 1'b1; exception_MEM_in = 1'b1;
      @(posedge clk); #1;
      idle_inputs(); cause_in = 3'd5; epc_in = 32'h500;
      @(posedge clk); #1;
      imem_ack = 1'b1; imem_rdata = 16'h1111;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      chk("vec_lo_req", 3, observed(), pk(1, 32'd13, 4'b0, 1, 0, 0, 0, 0));
      #2 reset = 1'b1;
      #1;
      chk("async_reset_vec_lo", 3, observed(), '0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
      run(tbl[0]);

      for (int i = 0; i < 40; i++) begin
         rs.flags = 3'($urandom);
         rs.cause = 3'($urandom);
         rs.epc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         rs.hi    = 16'($urandom);
         rs.lo    = 16'($urandom);
         rs.d1    = $urandom_range(0, 4);
         rs.d2    = $urandom_range(0, 4);
         rs.k     = $urandom_range(0, 3);
         rs.dbl     = ($urandom_range(0, 4) == 0);
         rs.rti_too = 1'($urandom_range(0, 1));
         rs.noise   = 1'($urandom_range(0, 1));
         rs.directed = 1'b0;
         rs.exp_mask = 4'b0; rs.exp_pc = 32'd0; rs.exp_ret = 32'd0;
         run(rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
